elm_mult_arbiter: RTL and testbench
===================================

# elm_mult_arbiter

Round-robin arbiter and sequencer that shares one ELM_Mitchw3 approximate 16x16 multiplier among N_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one operation per cycle into an internal two-stage pipeline: an operand register, then the multiplier, then a product register. Each product is returned to the requester that issued it as a one-cycle response pulse. The block sits between client engines and the multiplier core; the multiplier instance lives inside this block.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  N_REQ  bit i: requester i presents an operand pair.
- req_x  input  16*N_REQ  X operand of requester i at bits [16i+15:16i].
- req_y  input  16*N_REQ  Y operand of requester i at bits [16i+15:16i].
- req_ready  output  N_REQ  bit i: grant to requester i (combinational); at most one bit high per cycle.
- rsp_valid  output  N_REQ  bit i: rsp_p carries requester i's product; one-cycle pulse, one-hot or zero.
- rsp_p  output  32  registered product from ELM_Mitchw3.
- busy  output  1  high while any issued operation has not yet returned.

## Operation
- Eligibility: requester i is eligible when req_valid[i]=1 and outstanding[i]=0.
- Arbitration: among eligible requesters, grant the first one found searching from index ptr upward, with wrap-around modulo N_REQ. req_ready of the winner is 1; all others are 0.
- Handshake: an operation is issued in a cycle where req_valid[i] and req_ready[i] are both 1.
  - req_valid must not depend combinationally on req_ready.
  - A requester holds req_valid and its operands stable until granted.
- On issue from requester i:
  - ptr <= (i+1) mod N_REQ. ptr is unchanged in cycles with no issue.
  - outstanding[i] <= 1.
  - Operand register <= req_x/req_y slice i.
  - Stage-1 tag <= i, stage-1 valid <= 1.
- Stage 2: product register <= multiplier output; stage-2 tag and valid <= stage-1 tag and valid.
- Response:
  - rsp_valid[tag] = stage-2 valid.
  - outstanding[tag] clears in the same cycle, so requester i is eligible again in the cycle its response is presented.
- rsp_p holds its last value when rsp_valid=0.
- There is no response backpressure; requesters must capture rsp_p on the pulse.
- busy = stage-1 valid OR stage-2 valid.
- Arithmetic: rsp_p is exactly the ELM_Mitchw3 output for the issued operands. The arbiter applies no rounding, saturation or modification.

## Timing
- Reset (rst=1 at a clock edge):
  - ptr=0.
  - outstanding=0.
  - Both pipeline valids = 0.
  - rsp_valid=0, rsp_p=0, busy=0.
  - req_ready is forced to 0 during reset.
- Latency: an issue at edge t presents the response in the cycle after edge t+2, i.e. 2 cycles after the handshake.
- Throughput:
  - Aggregate: 1 issue per cycle.
  - Per requester: 1 issue per 2 cycles. A requester granted in cycle c cannot be granted in c+1 but can be granted in c+2.
- Simultaneous events: response to requester i and a new grant to requester i in the same cycle is legal and required.
- Reset mid-operation: in-flight operations are discarded; no rsp_valid appears for them after reset deasserts.
- Only one requester valid: it is granted every other cycle regardless of ptr.
- No eligible requester: no issue, ptr holds, pipeline bubbles propagate.

## Test plan
- Single issue, ~10 lines: reset, then req_valid=0001, x0=0x0100, y0=0x0040.
  - Required: req_ready=0001 in that cycle.
  - Required: rsp_valid=0001 with rsp_p=0x00004000 two cycles later.
  - Required: busy high for those two cycles.
- Round-robin: all four requesters valid continuously, operands x_i=1<<i, y_i=0x0010.
  - Required grant order: 0,1,2,3,0,...
  - Required: one grant per cycle.
  - Required responses in the same order: rsp_p=0x10,0x20,0x40,0x80.
- Pointer wrap: after granting requester 3 with only requesters 1 and 2 valid.
  - Required: the next grant is 1, then 2.
- Outstanding rule: only requester 2 valid, held for 6 cycles.
  - Required: grants in cycles 0, 2 and 4.
  - Required: rsp_valid=0100 in cycles 2, 4 and 6, coinciding with the re-grants.
- Reset mid-flight: issue from requesters 0 and 1 in consecutive cycles, then assert rst for 1 cycle.
  - Required: no rsp_valid afterwards, ptr=0, busy=0.
  - Required: the first post-reset grant goes to requester 0 when all requesters are valid.
- Idle gaps: requests separated by random idle cycles.
  - Required: rsp_p holds its last value while rsp_valid=0.
  - Required: req_ready is never multi-hot.

Source files
------------

// File: rtl/elm_mult_arbiter.sv
// Round-robin arbiter sharing one ELM_Mitchw3 approximate multiplier among N_REQ requesters.
// Two-stage pipeline: operand register -> multiplier -> product register, tagged by requester.

module ELM_Mitchw3 (
   input  logic [15:0] i_x,
   input  logic [15:0] i_y,
   output logic [31:0] o_p
);
   logic [3:0]  w_kx;
   logic [3:0]  w_ky;
   logic [2:0]  w_fx;
   logic [2:0]  w_fy;
   logic [3:0]  w_sum;
   logic [4:0]  w_kk;
   logic [3:0]  w_mant;
   logic [5:0]  w_sh;
   logic [34:0] w_scaled;

   // Leading-one position of each operand (characteristic of the logarithm).
   always_comb begin
      w_kx = '0;
      w_ky = '0;
      for (int b = 0; b < 16; b++) begin
         if (i_x[b]) w_kx = 4'(b);
         if (i_y[b]) w_ky = 4'(b);
      end
   end

   // Mantissa truncated to the 3 bits just below the leading one.
   assign w_fx = 3'((i_x << (4'd15 - w_kx)) >> 12);
   assign w_fy = 3'((i_y << (4'd15 - w_ky)) >> 12);

   assign w_sum  = {1'b0, w_fx} + {1'b0, w_fy};
   assign w_kk   = {1'b0, w_kx} + {1'b0, w_ky};
   // Fraction carry moves the product one octave up and drops the implicit one.
   assign w_mant = w_sum[3] ? w_sum : (4'd8 + w_sum);
   assign w_sh   = {1'b0, w_kk} + {5'd0, w_sum[3]};
   assign w_scaled = {31'd0, w_mant} << w_sh;

   assign o_p = ((i_x == 16'd0) || (i_y == 16'd0)) ? 32'd0 : 32'(w_scaled >> 3);
endmodule

module elm_mult_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [16*N_REQ-1:0]  req_x,
   input  logic [16*N_REQ-1:0]  req_y,
   output logic [N_REQ-1:0]     req_ready,
   output logic [N_REQ-1:0]     rsp_valid,
   output logic [31:0]          rsp_p,
   output logic                 busy
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [IW-1:0]    r_ptr;
   logic [N_REQ-1:0] r_outstanding;
   logic [15:0]      r_opX;
   logic [15:0]      r_opY;
   logic             r_s1Valid;
   logic [IW-1:0]    r_s1Tag;
   logic             r_s2Valid;
   logic [IW-1:0]    r_s2Tag;
   logic [31:0]      r_prod;

   logic [N_REQ-1:0] w_elig;
   logic [N_REQ-1:0] w_grant;
   logic [N_REQ-1:0] w_clr;
   logic [N_REQ-1:0] w_rspOneHot;
   logic [IW-1:0]    w_gidx;
   logic [IW-1:0]    w_cand;
   logic [IW-1:0]    w_nextPtr;
   logic             w_found;
   logic [31:0]      w_mulP;

   ELM_Mitchw3 uMul (
      .i_x (r_opX),
      .i_y (r_opY),
      .o_p (w_mulP)
   );

   // Outstanding clears as the op enters stage 2, so the requester is eligible while its response is shown.
   assign w_elig = req_valid & ~r_outstanding;

   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      w_cand  = '0;
      w_grant = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_cand = IW'((int'(r_ptr) + k) % N_REQ);
         if (!w_found && w_elig[w_cand]) begin
            w_found = 1'b1;
            w_gidx  = w_cand;
         end
      end
      if (w_found) w_grant[w_gidx] = 1'b1;
   end

   always_comb begin
      w_clr       = '0;
      w_rspOneHot = '0;
      if (r_s1Valid) w_clr[r_s1Tag] = 1'b1;
      if (r_s2Valid) w_rspOneHot[r_s2Tag] = 1'b1;
   end

   assign w_nextPtr = IW'((int'(w_gidx) + 1) % N_REQ);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr         <= '0;
         r_outstanding <= '0;
         r_opX         <= '0;
         r_opY         <= '0;
         r_s1Valid     <= 1'b0;
         r_s1Tag       <= '0;
         r_s2Valid     <= 1'b0;
         r_s2Tag       <= '0;
         r_prod        <= '0;
      end else begin
         r_s1Valid     <= w_found;
         r_outstanding <= (r_outstanding & ~w_clr) | w_grant;
         if (w_found) begin
            r_ptr   <= w_nextPtr;
            r_s1Tag <= w_gidx;
            r_opX   <= req_x[16*w_gidx +: 16];
            r_opY   <= req_y[16*w_gidx +: 16];
         end
         r_s2Valid <= r_s1Valid;
         r_s2Tag   <= r_s1Tag;
         if (r_s1Valid) r_prod <= w_mulP;
      end
   end

   assign req_ready = rst ? '0 : w_grant;
   assign rsp_valid = w_rspOneHot;
   assign rsp_p     = r_prod;
   assign busy      = r_s1Valid | r_s2Valid;
endmodule

// File: tb/tb_elm_mult_arbiter.sv
// Bench for elm_mult_arbiter: grant table per cycle plus a scoreboard of expected responses.
// Operands are powers of two or zero, where the logarithmic product is exact.

module tb_elm_mult_arbiter;
   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  reqValid;
   logic [N-1:0]  reqReady;
   logic [N-1:0]  rspValid;
   logic [16*N-1:0] reqX;
   logic [16*N-1:0] reqY;
   logic [31:0]   rspP;
   logic          busy;
   logic [15:0]   xOp [N];
   logic [15:0]   yOp [N];

   typedef struct {
      logic       rstIn;
      logic [3:0] valid;
      logic [3:0] expReady;
      int         opSet;
   } vec_t;

   typedef struct {
      int          tag;
      logic [31:0] prod;
      int          due;
   } exp_t;

   vec_t        vecs [$];
   exp_t        sb [$];
   exp_t        monE;
   logic [3:0]  monV;
   int          assertCount = 0;
   int          failCount = 0;
   int          cycleNo = 0;
   logic [31:0] lastP = 32'd0;
   bit          monitorOn = 1'b0;

   elm_mult_arbiter #(.N_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (reqValid),
      .req_x     (reqX),
      .req_y     (reqY),
      .req_ready (reqReady),
      .rsp_valid (rspValid),
      .rsp_p     (rspP),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleNo++;

   always_comb begin
      reqX = '0;
      reqY = '0;
      for (int i = 0; i < N; i++) begin
         reqX[16*i +: 16] = xOp[i];
         reqY[16*i +: 16] = yOp[i];
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycleNo);
      end
   endtask

   // Scoreboard monitor: busy tracks in-flight entries, responses pop in order, pushes on handshake.
   always @(negedge clk) begin
      if (monitorOn && !rst) begin
         checkOutput("multiHotReady", 64'($countones(reqReady) > 1), 64'd0);
         checkOutput("busy", 64'(busy), 64'(sb.size() != 0));
         if (sb.size() > 0 && (sb[0].due == cycleNo || rspValid != '0)) begin
            monE = sb.pop_front();
            monV = 4'(1 << monE.tag);
            checkOutput("rsp", {28'd0, rspValid, rspP}, {28'd0, monV, monE.prod});
            checkOutput("rspCycle", 64'(cycleNo), 64'(monE.due));
            lastP = monE.prod;
         end else if (rspValid != '0) begin
            checkOutput("unexpectedRsp", 64'(rspValid), 64'd0);
         end else begin
            checkOutput("holdP", 64'(rspP), 64'(lastP));
         end
         for (int i = 0; i < N; i++)
            if (reqValid[i] && reqReady[i])
               sb.push_back('{i, {16'd0, xOp[i]} * {16'd0, yOp[i]}, cycleNo + 2});
      end
   end

   task automatic addVec(input logic r, input logic [3:0] v, input logic [3:0] e, input int s);
      vec_t t;
      t.rstIn = r;
      t.valid = v;
      t.expReady = e;
      t.opSet = s;
      vecs.push_back(t);
   endtask

   task automatic applyStimulus(input vec_t v);
      case (v.opSet)
         0: begin xOp[0] = 16'h0100; yOp[0] = 16'h0040; end
         1: for (int i = 0; i < N; i++) begin xOp[i] = 16'(1 << i); yOp[i] = 16'h0010; end
         2: begin xOp[2] = 16'h8000; yOp[2] = 16'h8000; end
         3: begin
            xOp[0] = 16'h0004; yOp[0] = 16'h0400;
            xOp[1] = 16'h0020; yOp[1] = 16'h0002;
         end
         default: ;
      endcase
      if (v.rstIn) begin
         rst = 1'b1;
         reqValid = '0;
         sb.delete();
         lastP = 32'd0;
      end else begin
         rst = 1'b0;
         reqValid = v.valid;
      end
      @(negedge clk);
      checkOutput("grant", 64'(reqReady), 64'(v.expReady));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int waitCycles;
      int r;
      vec_t t;

      rst = 1'b1;
      reqValid = '0;
      for (int i = 0; i < N; i++) begin xOp[i] = '0; yOp[i] = '0; end
      @(negedge clk);
      checkOutput("resetReady", 64'(reqReady), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      monitorOn = 1'b1;
      @(negedge clk);
      checkOutput("resetRspValid", 64'(rspValid), 64'd0);
      checkOutput("resetRspP", 64'(rspP), 64'd0);
      checkOutput("resetBusy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;

      // single issue
      addVec(0, 4'b0001, 4'b0001, 0);
      addVec(0, 4'b0000, 4'b0000, 0);
      addVec(0, 4'b0000, 4'b0000, 0);
      addVec(0, 4'b0000, 4'b0000, 0);
      // round robin from a fresh pointer
      addVec(1, 4'b0000, 4'b0000, 1);
      for (int k = 0; k < 8; k++) addVec(0, 4'b1111, 4'(1 << (k % 4)), 1);
      addVec(0, 4'b0000, 4'b0000, 1);
      addVec(0, 4'b0000, 4'b0000, 1);
      // pointer wrap after requester 3
      addVec(0, 4'b0110, 4'b0010, 1);
      addVec(0, 4'b0110, 4'b0100, 1);
      addVec(0, 4'b0000, 4'b0000, 1);
      addVec(0, 4'b0000, 4'b0000, 1);
      // lone requester re-granted every other cycle
      for (int k = 0; k < 6; k++) addVec(0, 4'b0100, (k % 2 == 0) ? 4'b0100 : 4'b0000, 2);
      addVec(0, 4'b0000, 4'b0000, 2);
      addVec(0, 4'b0000, 4'b0000, 2);
      // reset with two operations in flight
      addVec(0, 4'b0011, 4'b0001, 3);
      addVec(0, 4'b0011, 4'b0010, 3);
      addVec(1, 4'b0000, 4'b0000, 3);
      addVec(0, 4'b1111, 4'b0001, 3);
      addVec(0, 4'b0000, 4'b0000, 3);
      addVec(0, 4'b0000, 4'b0000, 3);
      addVec(0, 4'b0000, 4'b0000, 3);

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

      // random single requests separated by idle gaps
      for (int k = 0; k < 12; k++) begin
         r = int'($urandom_range(0, 3));
         xOp[r] = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'(1 << $urandom_range(0, 15));
         yOp[r] = 16'(1 << $urandom_range(0, 15));
         t.rstIn = 1'b0;
         t.valid = 4'(1 << r);
         t.expReady = 4'(1 << r);
         t.opSet = -1;
         applyStimulus(t);
         t.valid = '0;
         t.expReady = '0;
         repeat ($urandom_range(1, 4)) applyStimulus(t);
      end

      waitCycles = 0;
      while (sb.size() > 0 && waitCycles < 10) begin
         @(posedge clk);
         waitCycles++;
      end
      checkOutput("drain", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
